// File: rtl/muladd_seq_pkg.sv
// Shared types and default widths for the MULADD dot-product sequencer.
package muladd_seq_pkg;

  localparam int DEF_OP_W  = 8;
  localparam int DEF_ACC_W = 20;
  localparam int DEF_LEN_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/muladd_seq_wdog.sv
// Idle-cycle watchdog for the RUN state: expires after TIMEOUT consecutive
// active cycles without a kick. Used only when MULADD_DOT_SEQ_TIMEOUT_EN is defined.
module muladd_seq_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic UserCLK,
  input  logic rst_n,
  input  logic active,
  input  logic kick,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] idle_cnt_reg;

  // Expiry fires during the TIMEOUT-th idle cycle so the sequencer leaves RUN on that edge.
  assign expired = active && !kick && (idle_cnt_reg == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge UserCLK or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_reg <= '0;
    end else if (!active || kick) begin
      idle_cnt_reg <= '0;
    end else if (!expired) begin
      idle_cnt_reg <= idle_cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/muladd_dot_seq.sv
// Dot-product sequencer driving an external MULADD (A_reg=0, B_reg=0, ACC=1, ACCout=1).
// Optional RUN timeout with error flag when MULADD_DOT_SEQ_TIMEOUT_EN is defined.
module muladd_dot_seq
  import muladd_seq_pkg::*;
#(
  parameter int OP_W    = DEF_OP_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int MAC_LAT = 1,
  parameter int TIMEOUT = 255
) (
  input  logic             UserCLK,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             res_err,
  output logic [OP_W-1:0]  mac_a,
  output logic [OP_W-1:0]  mac_b,
  output logic             mac_clr,
  input  logic [ACC_W-1:0] mac_q
);

  state_t           state_reg, state_next;
  logic [LEN_W-1:0] count_reg;
  logic [2:0]       drain_cnt_reg;
  logic [ACC_W-1:0] res_data_reg;
  logic             hs;
  logic             drain_last;
  logic             timeout_hit;

  assign hs         = in_valid && in_ready;
  assign drain_last = (drain_cnt_reg == 3'(MAC_LAT - 1));

  // Operands are zeroed outside a handshake so the accumulator adds nothing.
  assign mac_a    = hs ? in_a : '0;
  assign mac_b    = hs ? in_b : '0;
  assign res_data = res_data_reg;

`ifdef MULADD_DOT_SEQ_TIMEOUT_EN
  logic res_err_reg;

  muladd_seq_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .UserCLK (UserCLK),
    .rst_n   (rst_n),
    .active  (state_reg == ST_RUN),
    .kick    (hs),
    .expired (timeout_hit)
  );

  always_ff @(posedge UserCLK or negedge rst_n) begin
    if (!rst_n) begin
      res_err_reg <= 1'b0;
    end else if (state_reg == ST_IDLE && cmd_valid) begin
      res_err_reg <= 1'b0;
    end else if (state_reg == ST_RUN && timeout_hit) begin
      res_err_reg <= 1'b1;
    end
  end

  assign res_err = res_err_reg;
`else
  assign timeout_hit = 1'b0;
  assign res_err     = 1'b0;
`endif

  always_ff @(posedge UserCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_next = (cmd_len != '0) ? ST_RUN : ST_DRAIN;
        end
      end
      ST_RUN: begin
        if ((hs && count_reg == LEN_W'(1)) || timeout_hit) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_last) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    mac_clr   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        mac_clr   = 1'b1;
      end
      ST_RUN:  in_ready  = 1'b1;
      ST_DONE: res_valid = 1'b1;
      default: ;
    endcase
  end

  // Remaining-pair count, drain timer and result capture.
  always_ff @(posedge UserCLK or negedge rst_n) begin
    if (!rst_n) begin
      count_reg     <= '0;
      drain_cnt_reg <= '0;
      res_data_reg  <= '0;
    end else begin
      if (state_reg == ST_IDLE && cmd_valid) begin
        count_reg <= cmd_len;
      end else if (hs) begin
        count_reg <= count_reg - LEN_W'(1);
      end

      if (state_reg == ST_DRAIN) begin
        drain_cnt_reg <= drain_cnt_reg + 3'd1;
      end else begin
        drain_cnt_reg <= '0;
      end

      if (state_reg == ST_DRAIN && drain_last) begin
        res_data_reg <= mac_q;
      end
    end
  end

endmodule

// File: tb/tb_muladd_dot_seq.sv
// Directed bench for muladd_dot_seq with a behavioural MULADD (ACC=1, ACCout=1).
// Define MULADD_DOT_SEQ_TIMEOUT_EN to also exercise the RUN timeout.
module tb_muladd_dot_seq;

  localparam int OP_W  = 8;
  localparam int ACC_W = 20;
  localparam int LEN_W = 8;

  logic             UserCLK = 1'b0;
  logic             rst_n;
  logic             cmd_valid, cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             in_valid, in_ready;
  logic [OP_W-1:0]  in_a, in_b;
  logic             res_valid, res_ready;
  logic [ACC_W-1:0] res_data;
  logic             res_err;
  logic [OP_W-1:0]  mac_a, mac_b;
  logic             mac_clr;
  logic [ACC_W-1:0] mac_q;

  int errors = 0;
  int checks = 0;

  always #5 UserCLK = ~UserCLK;

  muladd_dot_seq #(
    .OP_W    (OP_W),
    .ACC_W   (ACC_W),
    .LEN_W   (LEN_W),
    .MAC_LAT (1),
    .TIMEOUT (8)
  ) dut (
    .UserCLK   (UserCLK),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_clr   (mac_clr),
    .mac_q     (mac_q)
  );

  // MULADD model: unregistered A/B, registered accumulator output, clr reloads with the product.
  logic signed [ACC_W-1:0] pa, pb;
  logic [ACC_W-1:0]        acc_q = '0;
  assign pa    = {{(ACC_W-OP_W){mac_a[OP_W-1]}}, mac_a};
  assign pb    = {{(ACC_W-OP_W){mac_b[OP_W-1]}}, mac_b};
  assign mac_q = acc_q;
  always @(posedge UserCLK) begin
    acc_q <= mac_clr ? ACC_W'(pa * pb) : acc_q + ACC_W'(pa * pb);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one cycle, then confirm the three ready/valid outputs are mutually exclusive.
  task automatic step();
    logic excl_ok;
    @(posedge UserCLK);
    #1;
    excl_ok = !((cmd_ready && in_ready) || (cmd_ready && res_valid) || (in_ready && res_valid));
    chk("excl", 32'(excl_ok), 1);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; res_ready = 1'b0;
    #2;
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_in_ready",  32'(in_ready), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_data",  32'(res_data), 0);
    chk("rst_res_err",   32'(res_err), 0);
    chk("rst_mac_clr",   32'(mac_clr), 1);
    in_valid = 1'b1; in_a = 8'd50; in_b = 8'd50;
    #1;
    chk("rst_mac_a", 32'(mac_a), 0);
    chk("rst_mac_b", 32'(mac_b), 0);
    step(); step();
    rst_n = 1'b1;
    step();
    #1;
    chk("idle_in_ready", 32'(in_ready), 0);
    chk("idle_mac_a",    32'(mac_a), 0);

    // len=3, back-to-back pairs: 6 - 20 + 49 = 35
    in_valid = 1'b0; cmd_valid = 1'b1; cmd_len = 8'd3;
    step();
    cmd_valid = 1'b0; in_valid = 1'b1; in_a = 8'd2; in_b = 8'd3;
    #1;
    chk("t1_in_ready", 32'(in_ready), 1);
    chk("t1_mac_a",    32'(mac_a), 2);
    chk("t1_mac_b",    32'(mac_b), 3);
    chk("t1_mac_clr",  32'(mac_clr), 0);
    step();
    in_a = -8'sd4; in_b = 8'd5;
    #1;
    chk("t1_mac_a_neg", 32'(mac_a), 'hFC);
    step();
    in_a = 8'd7; in_b = 8'd7;
    step();
    in_valid = 1'b0;
    #1;
    chk("t1_drain_res_valid", 32'(res_valid), 0);
    chk("t1_drain_in_ready",  32'(in_ready), 0);
    step();
    chk("t1_res_valid", 32'(res_valid), 1);
    chk("t1_res_data",  32'(res_data), 35);
    chk("t1_res_err",   32'(res_err), 0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("t1_back_idle", 32'(cmd_ready), 1);
    chk("t1_idle_clr",  32'(mac_clr), 1);

    // len=0 with in_valid held high: straight to DRAIN, no operand accepted
    cmd_valid = 1'b1; cmd_len = 8'd0; in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9;
    step();
    cmd_valid = 1'b0;
    #1;
    chk("t2_drain_in_ready", 32'(in_ready), 0);
    chk("t2_drain_mac_a",    32'(mac_a), 0);
    chk("t2_drain_res_valid", 32'(res_valid), 0);
    step();
    chk("t2_res_valid", 32'(res_valid), 1);
    chk("t2_res_data",  32'(res_data), 0);
    chk("t2_in_ready",  32'(in_ready), 0);
    res_ready = 1'b1; in_valid = 1'b0;
    step();
    res_ready = 1'b0;

    // len=4, (1,1) with 3-cycle gaps, then res_ready held low for 5 cycles
    cmd_valid = 1'b1; cmd_len = 8'd4;
    step();
    cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_a = 8'd1; in_b = 8'd1;
      #1;
      chk("t3_pair_mac_a", 32'(mac_a), 1);
      step();
      if (k < 3) begin
        for (int g = 0; g < 3; g++) begin
          in_valid = 1'b0; in_a = 8'd9; in_b = 8'd9;
          #1;
          chk("t3_gap_mac_a",    32'(mac_a), 0);
          chk("t3_gap_mac_b",    32'(mac_b), 0);
          chk("t3_gap_in_ready", 32'(in_ready), 1);
          step();
        end
      end
    end
    in_valid = 1'b0;
    step();
    for (int w = 0; w < 5; w++) begin
      chk("t3_res_valid", 32'(res_valid), 1);
      chk("t3_res_data",  32'(res_data), 4);
      step();
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("t3_back_idle", 32'(res_valid), 0);

    // len=255 of (-128,-128): 255*16384 = 4177920, mod 2^20 = 1032192
    cmd_valid = 1'b1; cmd_len = 8'd255;
    step();
    cmd_valid = 1'b0; in_valid = 1'b1; in_a = 8'h80; in_b = 8'h80;
    for (int i = 0; i < 255; i++) begin
      if (i == 254) begin
        #1;
        chk("t4_last_in_ready", 32'(in_ready), 1);
      end
      step();
    end
    #1;
    chk("t4_drain_in_ready", 32'(in_ready), 0);
    in_valid = 1'b0;
    step();
    chk("t4_res_valid", 32'(res_valid), 1);
    chk("t4_res_data",  32'(res_data), 1032192);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    // Reset after 2 of 5 pairs, then len=1 (3,3) must give 9 with no leftover
    cmd_valid = 1'b1; cmd_len = 8'd5;
    step();
    cmd_valid = 1'b0; in_valid = 1'b1; in_a = 8'd2; in_b = 8'd2;
    step(); step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_cmd_ready", 32'(cmd_ready), 1);
    chk("t5_rst_in_ready",  32'(in_ready), 0);
    chk("t5_rst_mac_clr",   32'(mac_clr), 1);
    chk("t5_rst_res_valid", 32'(res_valid), 0);
    chk("t5_rst_res_data",  32'(res_data), 0);
    step(); step();
    rst_n = 1'b1;
    step();
    cmd_valid = 1'b1; cmd_len = 8'd1;
    step();
    cmd_valid = 1'b0; in_valid = 1'b1; in_a = 8'd3; in_b = 8'd3;
    step();
    in_valid = 1'b0;
    step();
    chk("t5_res_valid", 32'(res_valid), 1);
    chk("t5_res_data",  32'(res_data), 9);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

`ifdef MULADD_DOT_SEQ_TIMEOUT_EN
    // len=3, one pair (5,5), then 8 silent cycles force DRAIN with the error flag
    cmd_valid = 1'b1; cmd_len = 8'd3;
    step();
    cmd_valid = 1'b0; in_valid = 1'b1; in_a = 8'd5; in_b = 8'd5;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        #1;
        chk("t6_still_run", 32'(in_ready), 1);
      end
      step();
    end
    chk("t6_drain_in_ready", 32'(in_ready), 0);
    step();
    chk("t6_res_valid", 32'(res_valid), 1);
    chk("t6_res_data",  32'(res_data), 25);
    chk("t6_res_err",   32'(res_err), 1);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
